pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the IF/ID and ID/EX stage registers. Detects load-use

---
 rtl/pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Pipeline sequencer for the IF/ID and ID/EX stage registers. It detects
// load-use hazards against the instruction held in ID/EX. It flushes the
// front end on taken branches resolved in EX. It freezes fetch while
// downstream logic asks for a stall. ID/EX has no enable, so every stall
// cycle injects a bubble (zeroed control) into ID/EX.
//
// Parameters
//   REG_AW        register-index width
//   FLUSH_CYCLES  bubble/flush cycles per taken branch (>= 1)
//   CNT_W         stall-counter width
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   id_rs1/id_rs2    source registers of the instruction in ID
//   id_uses_rs2      ID instruction actually reads rs2
//   ex_memread       instruction in ID/EX is a load
//   ex_rd            destination register of the instruction in ID/EX
//   ex_branch_taken  taken branch/jump resolved in EX this cycle
//   ext_stall_req    downstream not ready
//   pc_we            PC write enable
//   if_id_we         IF/ID write enable
//   if_id_flush      load a NOP into IF/ID
//   id_ex_bubble     force zeroed control into ID/EX
//   ctrl_state       00 RUN, 01 FLUSH, 10 HOLD
//   stall_cnt        saturating count of bubble cycles since reset
//
// Build option
//   HAZ_PERF_CNT_EN  when defined, the stall_cnt counter is built.
//                    When undefined, stall_cnt is tied to zero. The port is
//                    kept so that top-level wiring does not change.
//
// Outputs are combinational from the registered state and the current
// inputs. Hazard response therefore takes effect in the same cycle.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              ext_stall_req,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [1:0]        ctrl_state,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_FLUSH = 2'b01;
  localparam logic [1:0] ST_HOLD  = 2'b10;

  localparam logic [FCNT_W-1:0] FCNT_ZERO   = {FCNT_W{1'b0}};
  localparam logic [FCNT_W-1:0] FCNT_ONE    = FCNT_W'(1);
  localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);

  // A single-cycle flush never needs the FLUSH state. The branch cycle
  // itself is the only flush cycle.
  localparam logic [1:0] ST_AFTER_BR = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;

  logic [1:0]        state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q,  fcnt_d;
  logic              load_use;

  // Load-use hazard: a load in EX writes a register that ID is reading.
  // x0 is never a hazard.
  always_comb begin
    load_use = ex_memread && (ex_rd != {REG_AW{1'b0}}) &&
               ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  end

  // Next-state and output decode.
  // RUN and HOLD share the same decode: a set stall request (re)enters HOLD,
  // and a clear one returns to RUN. A clear stall request in HOLD is
  // therefore a normal RUN cycle, so a pending load-use still costs its one
  // bubble. The illegal encoding 11 decodes as RUN but always recovers to RUN.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    case (state_q)
      ST_FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (ex_branch_taken) begin
          fcnt_d  = FCNT_RELOAD;
          state_d = ST_AFTER_BR;
        end else if (fcnt_q <= FCNT_ONE) begin
          // Last flush cycle: a stall request seen now goes straight to HOLD.
          fcnt_d  = FCNT_ZERO;
          state_d = ext_stall_req ? ST_HOLD : ST_RUN;
        end else begin
          fcnt_d  = fcnt_q - FCNT_ONE;
          state_d = ST_FLUSH;
        end
      end
      default: begin
        if (ex_branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          fcnt_d       = FCNT_RELOAD;
          state_d      = ST_AFTER_BR;
        end else if (ext_stall_req) begin
          pc_we        = 1'b0;
          if_id_we     = 1'b0;
          id_ex_bubble = 1'b1;
          fcnt_d       = FCNT_ZERO;
          state_d      = ST_HOLD;
        end else if (load_use) begin
          pc_we        = 1'b0;
          if_id_we     = 1'b0;
          id_ex_bubble = 1'b1;
          fcnt_d       = FCNT_ZERO;
          state_d      = ST_RUN;
        end else begin
          fcnt_d  = FCNT_ZERO;
          state_d = ST_RUN;
        end
        if (state_q == 2'b11) begin
          fcnt_d  = FCNT_ZERO;
          state_d = ST_RUN;
        end else begin
          fcnt_d  = fcnt_d;
          state_d = state_d;
        end
      end
    endcase
  end

  // Sequencer state and flush counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      fcnt_q  <= FCNT_ZERO;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign ctrl_state = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating bubble counter. It holds at all-ones instead of wrapping.
  always_comb begin
    if (id_ex_bubble && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Bubble counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Table-driven bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, CNT_W=4). Each
// table row holds one cycle of inputs and the outputs expected in that
// cycle. Hand-written sequences cover reset asserted mid-flush and counter
// saturation. The expected stall count is modelled here. It steps on each
// edge where a bubble was expected, and it stays 0 when HAZ_PERF_CNT_EN is
// undefined.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs2, ex_memread, ex_branch_taken, ext_stall_req;
  logic          pc_we, if_id_we, if_id_flush, id_ex_bubble;
  logic [1:0]    ctrl_state;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt = 4'd0;

  pipe_hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ext_stall_req(ext_stall_req),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ctrl_state(ctrl_state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       uses, mr;
    logic [4:0] rd;
    logic       br, st;
    logic [3:0] o;   // {pc_we, if_id_we, if_id_flush, id_ex_bubble}
    logic [1:0] s;
  } vec_t;

  localparam logic [3:0] N = 4'b1100;  // normal
  localparam logic [3:0] S = 4'b0001;  // stall bubble
  localparam logic [3:0] F = 4'b1111;  // flush

  vec_t tbl [32];
  int   nvec = 0;

  function automatic void add(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic uses, input logic mr, input logic [4:0] rd,
                              input logic br, input logic st,
                              input logic [3:0] o, input logic [1:0] s);
    tbl[nvec] = '{rs1:rs1, rs2:rs2, uses:uses, mr:mr, rd:rd, br:br, st:st, o:o, s:s};
    nvec++;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] bump(input logic [CW-1:0] c);
`ifdef HAZ_PERF_CNT_EN
    return (c == {CW{1'b1}}) ? c : c + 4'd1;
`else
    return c;
`endif
  endfunction

  task automatic check_outs(input string nm, input logic [3:0] o, input logic [1:0] s);
    chk({nm, ".pc_we"},        {31'd0, pc_we},        {31'd0, o[3]});
    chk({nm, ".if_id_we"},     {31'd0, if_id_we},     {31'd0, o[2]});
    chk({nm, ".if_id_flush"},  {31'd0, if_id_flush},  {31'd0, o[1]});
    chk({nm, ".id_ex_bubble"}, {31'd0, id_ex_bubble}, {31'd0, o[0]});
    chk({nm, ".ctrl_state"},   {30'd0, ctrl_state},   {30'd0, s});
    chk({nm, ".stall_cnt"},    {28'd0, stall_cnt},    {28'd0, exp_cnt});
  endtask

  // Drive one cycle of inputs, check at the falling edge, then advance.
  task automatic apply(input vec_t v, input string nm);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs2 = v.uses; ex_memread = v.mr;
    ex_rd = v.rd; ex_branch_taken = v.br; ext_stall_req = v.st;
    @(negedge clk);
    check_outs(nm, v.o, v.s);
    @(posedge clk);
    if (v.o[0]) exp_cnt = bump(exp_cnt);
    #1;
  endtask

  vec_t v;

  initial begin
    reset = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0; ex_memread = 1'b0;
    ex_rd = 5'd0; ex_branch_taken = 1'b0; ext_stall_req = 1'b0;

    //   rs1    rs2    us    mr    rd     br    st    out st
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, N, 2'b00);  // idle
    add(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, S, 2'b00);  // load-use rs1
    add(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, N, 2'b00);  // load gone
    add(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, N, 2'b00);  // x0 never stalls
    add(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, N, 2'b00);  // rs2 unused
    add(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, S, 2'b00);  // rs2 used
    add(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, N, 2'b00);
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, F, 2'b00);  // branch
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, F, 2'b01);  // 2nd flush cycle
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, N, 2'b00);
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, F, 2'b00);  // branch
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, F, 2'b01);  // branch in FLUSH
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, F, 2'b01);
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, N, 2'b00);
    add(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, S, 2'b00);  // stall+load-use
    add(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, S, 2'b10);
    add(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, S, 2'b10);
    add(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, S, 2'b10);  // load-use bubble
    add(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, N, 2'b00);
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, F, 2'b00);  // branch
    add(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, F, 2'b01);  // stall ignored, ->HOLD
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, S, 2'b10);
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, F, 2'b10);  // branch in HOLD
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, F, 2'b01);
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, N, 2'b00);
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, F, 2'b00);  // branch beats stall
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, F, 2'b01);
    add(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, N, 2'b00);

    // Reset state
    @(negedge clk);
    check_outs("reset", N, 2'b00);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < nvec; i++) apply(tbl[i], $sformatf("v%0d", i));

    // Reset asserted in the middle of a flush
    v = '{rs1:5'd0, rs2:5'd0, uses:1'b0, mr:1'b0, rd:5'd0, br:1'b1, st:1'b0, o:F, s:2'b00};
    apply(v, "rst_br");
    ex_branch_taken = 1'b0;
    reset = 1'b0;
    exp_cnt = 4'd0;
    #1;
    check_outs("rst_mid_flush", N, 2'b00);
    @(posedge clk); #1;
    reset = 1'b1;
    v = '{rs1:5'd0, rs2:5'd0, uses:1'b0, mr:1'b0, rd:5'd0, br:1'b0, st:1'b0, o:N, s:2'b00};
    apply(v, "rst_release");

    // 20 bubble cycles from an external stall
    for (int k = 0; k < 20; k++) begin
      v = '{rs1:5'd0, rs2:5'd0, uses:1'b0, mr:1'b0, rd:5'd0, br:1'b0, st:1'b1,
            o:S, s:(k == 0) ? 2'b00 : 2'b10};
      apply(v, $sformatf("hold%0d", k));
    end
    v = '{rs1:5'd0, rs2:5'd0, uses:1'b0, mr:1'b0, rd:5'd0, br:1'b0, st:1'b0, o:N, s:2'b10};
    apply(v, "hold_exit");
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt_sat", {28'd0, stall_cnt}, 32'hF);
`else
    chk("stall_cnt_off", {28'd0, stall_cnt}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
